// File: rtl/mem_responder.sv
// Word-addressed data memory with a fixed-latency request/response controller.
// One request at a time; out-of-range and read+write requests are flagged on err.
module mem_responder #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              read_req,
  input  logic              write_req,
  input  logic [ADDR_W-1:0] addrout,
  input  logic [DATA_W-1:0] datatomem,
  output logic [DATA_W-1:0] datafrommem,
  output logic              mem_resp,
  output logic              busy,
  output logic              err
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic              op_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic            in_range;
  logic            done;
  logic            mem_we;
  logic [IdxW-1:0] mem_idx;

  // Full-width compare: addresses at or above DEPTH never alias into the array.
  assign in_range = 32'(addr_q) < DEPTH;
  assign done     = (state_q == StWait) && (cnt_q == 8'd0);
  assign mem_idx  = addr_q[IdxW-1:0];
  assign mem_we   = done && op_wr_q && in_range && !reset;

  // Access happens on the edge that enters RESP, LATENCY edges after acceptance.
  // With LATENCY=1 the counter loads 0, so WAIT lasts a single cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      op_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      datafrommem <= '0;
      mem_resp    <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      mem_resp <= 1'b0;
      err      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cs && (read_req ^ write_req)) begin
            op_wr_q <= write_req;
            addr_q  <= addrout;
            wdata_q <= datatomem;
            cnt_q   <= 8'(LATENCY - 1);
            state_q <= StWait;
            busy    <= 1'b1;
          end else if (cs && read_req && write_req) begin
            err <= 1'b1;
          end
        end
        StWait: begin
          if (cnt_q == 8'd0) begin
            state_q  <= StResp;
            mem_resp <= 1'b1;
            err      <= !in_range;
            if (!op_wr_q) begin
              datafrommem <= in_range ? mem[mem_idx] : '0;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= wdata_q;
    end
  end

endmodule
